// File: rtl/pipelined_prefix_sum.sv
// Pipelined Ladner-Fischer prefix-count over a lane mask with valid/ready on both sides.
// Streaming mode carries a running base offset across beats until the last-beat marker.
module pipelined_prefix_sum #(
    parameter int unsigned MASK_WIDTH     = 128,
    parameter int unsigned LEVELS_PER_REG = 2,
    parameter int unsigned ACC_WIDTH      = 16,
    parameter bit          EXCLUSIVE      = 1'b0,
    parameter bit          STREAMING      = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MASK_WIDTH-1:0]           in_mask,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MASK_WIDTH*ACC_WIDTH-1:0] out_psum,
    output logic [ACC_WIDTH-1:0]            out_total,
    output logic                            out_last
);

    localparam int unsigned LOG  = $clog2(MASK_WIDTH);
    localparam int unsigned NREG = (LOG + LEVELS_PER_REG - 1) / LEVELS_PER_REG;
    localparam int unsigned CW   = LOG + 1;

    typedef logic [MASK_WIDTH-1:0][CW-1:0] node_vec_t;

    // stg_d[s] feeds stage s; stg_d[NREG] is the finished inclusive prefix
    node_vec_t       stg_d [NREG+1];
    logic [NREG-1:0] v_q;
    logic [NREG-1:0] l_q;
    logic [NREG:0]   up_v;
    logic [NREG:0]   up_l;
    logic [NREG:0]   rdy;

    assign up_v     = {v_q, in_valid};
    assign up_l     = {l_q, in_last};
    assign in_ready = rdy[0];

    for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_in
        assign stg_d[0][i] = CW'(in_mask[i]);
    end

    // Ready ripples back from the output register through every stage
    always_comb begin
        rdy       = '0;
        rdy[NREG] = !out_valid || out_ready;
        for (int s = int'(NREG) - 1; s >= 0; s--) begin
            rdy[s] = !v_q[s] || rdy[s+1];
        end
    end

    for (genvar s = 0; s < NREG; s++) begin : g_stage
        localparam int unsigned K_LO = s * LEVELS_PER_REG + 1;
        localparam int unsigned K_HI = ((s + 1) * LEVELS_PER_REG < LOG) ?
                                       (s + 1) * LEVELS_PER_REG : LOG;
        localparam int unsigned SW   = K_HI + 1;

        node_vec_t                     lv;
        node_vec_t                     prev;
        logic [MASK_WIDTH-1:0][SW-1:0] data_d;
        logic [MASK_WIDTH-1:0][SW-1:0] data_q;
        logic                          vld_q;
        logic                          lst_q;

        // Levels K_LO..K_HI: node i absorbs the last node of the preceding block
        always_comb begin
            lv   = stg_d[s];
            prev = lv;
            for (int unsigned k = K_LO; k <= K_HI; k++) begin
                prev = lv;
                for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                    if (((i >> (k - 1)) & 32'd1) == 32'd1) begin
                        lv[i] = prev[i] + prev[i - 1 - (i % (32'd1 << (k - 1)))];
                    end
                end
            end
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                data_d[i] = SW'(lv[i]);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= 1'b0;
                lst_q  <= 1'b0;
                data_q <= '0;
            end else if (clear) begin
                vld_q <= 1'b0;
            end else if (rdy[s]) begin
                vld_q <= up_v[s];
                if (up_v[s]) begin
                    data_q <= data_d;
                    lst_q  <= up_l[s];
                end
            end
        end

        assign v_q[s] = vld_q;
        assign l_q[s] = lst_q;
        for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_ext
            assign stg_d[s+1][i] = CW'(data_q[i]);
        end
    end

    node_vec_t                      pin;
    logic [ACC_WIDTH-1:0]           base_q;
    logic [ACC_WIDTH-1:0]           tot_d;
    logic [MASK_WIDTH*ACC_WIDTH-1:0] psum_d;

    assign pin = stg_d[NREG];

    // Widen to ACC_WIDTH and add the running base
    always_comb begin
        tot_d  = base_q + ACC_WIDTH'(pin[MASK_WIDTH-1]);
        psum_d = '0;
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (EXCLUSIVE) begin
                psum_d[i*ACC_WIDTH +: ACC_WIDTH] = base_q +
                    ((i == 0) ? '0 : ACC_WIDTH'(pin[(i == 0) ? 0 : i - 1]));
            end else begin
                psum_d[i*ACC_WIDTH +: ACC_WIDTH] = base_q + ACC_WIDTH'(pin[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_psum  <= '0;
            out_total <= '0;
            out_last  <= 1'b0;
            base_q    <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            base_q    <= '0;
        end else if (rdy[NREG]) begin
            out_valid <= up_v[NREG];
            if (up_v[NREG]) begin
                out_psum  <= psum_d;
                out_total <= tot_d;
                out_last  <= up_l[NREG];
                base_q    <= (up_l[NREG] || !STREAMING) ? '0 : tot_d;
            end
        end
    end

endmodule

// File: doc/pipelined_prefix_sum.md
Name: pipelined_prefix_sum

Overview:
Parametrised, pipelined Ladner-Fischer prefix-count unit for the redundancy controller's mask compaction path. It accepts one MASK_WIDTH-bit mask per beat and returns, for every lane, the inclusive or exclusive count of set mask bits. Streaming mode is optional: a running base offset is carried across beats until a last-beat marker, giving global compaction indices over a multi-beat packet. Valid/ready handshakes on both sides, with full backpressure.

Parameters:
MASK_WIDTH, 128, lanes per beat; a power of 2, at least 2; LOG = log2(MASK_WIDTH)
LEVELS_PER_REG, 2, Ladner-Fischer levels between pipeline registers; range 1..LOG
ACC_WIDTH, 16, width of each output count and of the running base; at least LOG+1
EXCLUSIVE, 0, 0 = inclusive prefix, 1 = exclusive prefix
STREAMING, 1, 1 = carry base across beats until in_last; 0 = base is always 0

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush: empties the pipeline and zeroes the base
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_mask  in  MASK_WIDTH  lane mask; bit i = lane i
in_last  in  1  last beat of packet
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_psum  out  MASK_WIDTH*ACC_WIDTH  lane i count at [i*ACC_WIDTH +: ACC_WIDTH]
out_total  out  ACC_WIDTH  base + popcount(mask) for this beat
out_last  out  1  in_last of this beat, delayed

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Pipeline depth: NREG = ceil(LOG/LEVELS_PER_REG) internal register stages, then one output register. Zero-stall latency from input handshake to out_valid is NREG+1 cycles. Throughput is one beat per cycle.
- Prefix structure: level k (k = 1..LOG) adds node [i - 1 - (i mod 2^(k-1))] into node i when floor(i/2^(k-1)) is odd; otherwise node i passes through. After level k, intermediate width is k+1 bits. Widen to ACC_WIDTH only at the output stage.
- Register stages: each stage holds valid, data, and a last bit. Stage s may load when it is empty or its contents move on in the same cycle (ready_s = !valid_s | ready_{s+1}). in_ready = ready_0, a combinational chain. A bubble-free, full-throughput pipeline is required; no skid buffer.
- Output stage: loads when (!out_valid | out_ready) and the upstream stage is valid. On load:
  - out_psum[i] = base + P[i], where P is the inclusive prefix, or the exclusive prefix if EXCLUSIVE (lane 0 = base).
  - out_total = base + T, where T = popcount of the beat.
  - base <= (in_last of beat | !STREAMING) ? 0 : base + T.
  - All additions wrap modulo 2^ACC_WIDTH; no saturation.
- Base update point: the base updates only when a beat loads into the output register. Beats therefore accumulate in acceptance order, independent of stalls.
- Stall: while out_valid && !out_ready, all outputs hold stable and stages back-fill. in_ready deasserts only when every stage is full.
- Simultaneous events: a load and an unload of the output register in the same cycle is permitted and is not a stall. A beat with in_last=1 and mask=0 still resets the base.
- Reset: async assertion clears all valid bits, base, out_psum, out_total and out_last to 0. out_valid=0 and in_ready=1 from the first cycle after deassertion.
- clear: has priority over all handshakes in its cycle. All valids and base go to 0 on the next edge, and beats in flight are dropped. in_ready is 1 in the cycle after. An input handshake in the clear cycle is discarded.
- Outputs are fully registered, except in_ready.

Test Plan:
- MASK_WIDTH=8, LEVELS_PER_REG=1, inclusive, out_ready=1, mask=8'b1011_0110, last=1 -> 4 cycles later out_psum lanes 0..7 = 0,1,2,2,3,4,4,5; out_total=5; base returns to 0.
- Same config with EXCLUSIVE=1, same mask -> lanes = 0,0,1,2,2,3,4,4; out_total=5.
- Streaming, MASK_WIDTH=8: beats 8'hFF (last=0), 8'h01 (last=0), 8'h80 (last=1), 8'h03 (last=1) -> out_total = 8, 9, 10, 2; beat 2 lane 0 = 9; beat 4 lane 1 = 2.
- Defaults (128/2): back-to-back 20 random beats with out_ready toggling at random -> every beat emitted exactly once, in order, matching the model. Zero-stall latency is 5 cycles. Outputs are stable while stalled. in_ready falls only after 5 beats are pending.
- ACC_WIDTH=4, MASK_WIDTH=8, all-ones beats with last=0 -> out_total = 8, 0, 8, 0 (wraps modulo 16).
- Mid-packet: with 3 beats in flight, assert clear (and, on a separate run, reset_n) -> no further out_valid from those beats. The next beat 8'h01, last=1, gives out_total=1.
